// File: rtl/vec_mul_sequencer.sv
// Sequences one matrix-vector job: weight tile load, UB address stream, aligned result writes.
// Optional weight-tile reuse is compiled in with `define SEQ_WEIGHT_CACHE_EN.
module vec_mul_sequencer #(
  parameter int unsigned ADDRESSSIZE = 10,
  parameter int unsigned WADDRSIZE   = 2,
  parameter int unsigned RADDRSIZE   = 6,
  parameter int unsigned RESULT_LAT  = 2
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ADDRESSSIZE-1:0] src_base,
  input  logic [ADDRESSSIZE-1:0] num_vec,
  input  logic [WADDRSIZE-1:0]   weight_sel,
  output logic [ADDRESSSIZE-1:0] sram_address,
  output logic [WADDRSIZE-1:0]   weight_address,
  output logic                   weight_reload,
  output logic                   result_write_enable,
  output logic [RADDRSIZE-1:0]   result_address,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [2:0] {StIdle, StWaddr, StWreload, StStream, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [ADDRESSSIZE-1:0] base_q, num_q, cnt_q, cnt_d;
  logic [RESULT_LAT-1:0]  pipe_q, pipe_d;
  logic [ADDRESSSIZE-1:0] sram_address_d;
  logic [WADDRSIZE-1:0]   weight_address_d;
  logic [RADDRSIZE-1:0]   result_address_d;
  logic                   weight_reload_d, busy_d, done_d;
  logic                   accept, issuing, last_issue, active_abort, cache_hit;

  assign active_abort        = abort && (state_q != StIdle);
  assign accept              = (state_q == StIdle) && start;
  assign issuing             = (state_q == StStream);
  assign last_issue          = issuing && (cnt_q == num_q - ADDRESSSIZE'(1));
  assign result_write_enable = pipe_q[RESULT_LAT-1];

`ifdef SEQ_WEIGHT_CACHE_EN
  logic                 cache_valid_q;
  logic [WADDRSIZE-1:0] cache_sel_q;

  assign cache_hit = cache_valid_q && (weight_sel == cache_sel_q);

  // weight_address equals the tile being loaded throughout WRELOAD
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cache_valid_q <= 1'b0;
      cache_sel_q   <= '0;
    end else if (abort && ((state_q == StWaddr) || (state_q == StWreload))) begin
      cache_valid_q <= 1'b0;
    end else if (state_q == StWreload) begin
      cache_valid_q <= 1'b1;
      cache_sel_q   <= weight_address;
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  // Issue-valid shift register; an abort flushes it so no late writes escape
  always_comb begin
    pipe_d = '0;
    if (!active_abort) begin
      pipe_d[0] = issuing;
      for (int k = 1; k < int'(RESULT_LAT); k++) begin
        pipe_d[k] = pipe_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (active_abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (num_vec == '0)  state_d = StDone;
            else if (cache_hit) state_d = StStream;
            else                state_d = StWaddr;
          end
        end
        StWaddr:   state_d = StWreload;
        StWreload: state_d = StStream;
        StStream:  if (last_issue) state_d = StDrain;
        StDrain:   if (pipe_d == '0) state_d = StDone;
        StDone:    state_d = StIdle;
        default:   state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with it
  always_comb begin
    weight_address_d = weight_address;
    sram_address_d   = sram_address;
    cnt_d            = cnt_q;
    result_address_d = result_address;
    weight_reload_d  = (state_d == StWreload);
    busy_d           = (state_d != StIdle);
    done_d           = (state_d == StDone);

    if (state_d == StWaddr) weight_address_d = weight_sel;

    if (state_d == StStream) begin
      if (state_q != StStream) begin
        sram_address_d = (state_q == StIdle) ? src_base : base_q;
        cnt_d          = '0;
      end else begin
        sram_address_d = sram_address + ADDRESSSIZE'(1);
        cnt_d          = cnt_q + ADDRESSSIZE'(1);
      end
    end

    if (accept)                   result_address_d = '0;
    else if (result_write_enable) result_address_d = result_address + RADDRSIZE'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      base_q         <= '0;
      num_q          <= '0;
      cnt_q          <= '0;
      pipe_q         <= '0;
      sram_address   <= '0;
      weight_address <= '0;
      result_address <= '0;
      weight_reload  <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      if (accept) begin
        base_q <= src_base;
        num_q  <= num_vec;
      end
      cnt_q          <= cnt_d;
      pipe_q         <= pipe_d;
      sram_address   <= sram_address_d;
      weight_address <= weight_address_d;
      result_address <= result_address_d;
      weight_reload  <= weight_reload_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

endmodule

// File: tb/tb_vec_mul_sequencer.sv
// Self-checking bench for vec_mul_sequencer: directed scenarios plus randomized jobs
// checked cycle by cycle against a timing model derived from the job parameters.
module tb_vec_mul_sequencer;
  localparam int unsigned AW  = 10;
  localparam int unsigned WW  = 2;
  localparam int unsigned RW  = 6;
  localparam int unsigned LAT = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] src_base = '0;
  logic [AW-1:0] num_vec = '0;
  logic [WW-1:0] weight_sel = '0;
  logic [AW-1:0] sram_address;
  logic [WW-1:0] weight_address;
  logic          weight_reload;
  logic          result_write_enable;
  logic [RW-1:0] result_address;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  // Model state: expected held output values and weight-cache contents
  logic [AW-1:0] m_sram  = '0;
  logic [WW-1:0] m_waddr = '0;
  logic [RW-1:0] m_raddr = '0;
  bit            mc_valid = 1'b0;
  logic [WW-1:0] mc_sel = '0;

  vec_mul_sequencer #(
    .ADDRESSSIZE(AW),
    .WADDRSIZE  (WW),
    .RADDRSIZE  (RW),
    .RESULT_LAT (LAT)
  ) dut (
    .clk                (clk),
    .rstn               (rstn),
    .start              (start),
    .abort              (abort),
    .src_base           (src_base),
    .num_vec            (num_vec),
    .weight_sel         (weight_sel),
    .sram_address       (sram_address),
    .weight_address     (weight_address),
    .weight_reload      (weight_reload),
    .result_write_enable(result_write_enable),
    .result_address     (result_address),
    .busy               (busy),
    .done               (done)
  );

  always #5 clk = ~clk;

  // Runs one job started in cycle 0 and checks every output for each following cycle.
  task automatic run_job(input logic [AW-1:0] base, input int n, input logic [WW-1:0] wsel,
                         input int abort_at, input int extra_start_at);
    bit hit, live, e_busy, e_done, e_rel, e_we;
    int off, d, last_c;
`ifdef SEQ_WEIGHT_CACHE_EN
    hit = (n != 0) && mc_valid && (mc_sel == wsel);
`else
    hit = 1'b0;
`endif
    off    = hit ? 1 : 3;
    d      = (n == 0) ? 1 : off + n + LAT;
    last_c = ((abort_at > 0) ? abort_at : d) + 3;
    @(posedge clk);
    #1;
    start      = 1'b1;
    src_base   = base;
    num_vec    = n[AW-1:0];
    weight_sel = wsel;
    @(negedge clk);
    for (int c = 1; c <= last_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start      = 1'b0;
        src_base   = AW'($urandom);
        num_vec    = AW'($urandom);
        weight_sel = WW'($urandom);
      end
      if (extra_start_at > 0 && c == extra_start_at) start = 1'b1;
      if (extra_start_at > 0 && c == extra_start_at + 1) start = 1'b0;
      if (abort_at > 0 && c == abort_at) abort = 1'b1;
      if (abort_at > 0 && c == abort_at + 1) abort = 1'b0;

      live   = (abort_at <= 0) || (c <= abort_at);
      e_busy = live && (c <= d);
      e_done = live && (c == d);
      e_rel  = live && (n > 0) && !hit && (c == 2);
      e_we   = live && (n > 0) && (c >= off + LAT) && (c < off + LAT + n);
      if (c == 1) m_raddr = '0;
      if (live && n > 0 && !hit && c == 1) m_waddr = wsel;
      if (live && n > 0 && c >= off && c < off + n) m_sram = base + AW'(c - off);

      checks++;
      if (busy !== e_busy) begin
        errors++;
        $display("FAIL busy n=%0d cycle %0d got %b exp %b", n, c, busy, e_busy);
      end
      checks++;
      if (done !== e_done) begin
        errors++;
        $display("FAIL done n=%0d cycle %0d got %b exp %b", n, c, done, e_done);
      end
      checks++;
      if (weight_reload !== e_rel) begin
        errors++;
        $display("FAIL weight_reload n=%0d cycle %0d got %b exp %b", n, c, weight_reload, e_rel);
      end
      checks++;
      if (result_write_enable !== e_we) begin
        errors++;
        $display("FAIL result_we n=%0d cycle %0d got %b exp %b", n, c, result_write_enable, e_we);
      end
      checks++;
      if (sram_address !== m_sram) begin
        errors++;
        $display("FAIL sram_address n=%0d cycle %0d got %h exp %h", n, c, sram_address, m_sram);
      end
      checks++;
      if (weight_address !== m_waddr) begin
        errors++;
        $display("FAIL weight_address cycle %0d got %0d exp %0d", c, weight_address, m_waddr);
      end
      checks++;
      if (result_address !== m_raddr) begin
        errors++;
        $display("FAIL result_address cycle %0d got %0d exp %0d", c, result_address, m_raddr);
      end
      if (e_we) m_raddr = m_raddr + RW'(1);
    end
    start = 1'b0;
    abort = 1'b0;
    if (n > 0 && !hit) begin
      if (abort_at > 0 && abort_at <= 2) begin
        mc_valid = 1'b0;
      end else begin
        mc_valid = 1'b1;
        mc_sel   = wsel;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, done, weight_reload, result_write_enable} !== 4'b0 || sram_address !== '0 ||
        weight_address !== '0 || result_address !== '0) begin
      errors++;
      $display("FAIL reset_values got busy=%b done=%b rel=%b we=%b sa=%h wa=%0d ra=%0d exp all 0",
               busy, done, weight_reload, result_write_enable, sram_address, weight_address,
               result_address);
    end
    @(negedge clk);
    rstn  = 1'b1;
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || weight_reload !== 1'b0) begin
        errors++;
        $display("FAIL idle_abort got busy=%b done=%b rel=%b exp 0 0 0", busy, done,
                 weight_reload);
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_basic();
    run_job(10'h010, 4, 2'd2, -1, -1);
  endtask

  task automatic test_zero_len();
    run_job(10'h123, 0, 2'd1, -1, -1);
  endtask

  task automatic test_wrap();
    run_job(10'h3FE, 4, 2'd0, -1, -1);
    run_job(10'h200, 70, 2'd0, -1, -1);
  endtask

  task automatic test_abort();
    run_job(10'h010, 4, 2'd2, 4, -1);
    run_job(10'h020, 3, 2'd1, 1, -1);
    run_job(10'h030, 5, 2'd3, -1, -1);
  endtask

  task automatic test_ignored_start();
    run_job(10'h010, 4, 2'd2, -1, 4);
  endtask

  task automatic test_cache();
    run_job(10'h040, 3, 2'd1, -1, -1);
    run_job(10'h050, 3, 2'd1, -1, -1);
    run_job(10'h060, 3, 2'd3, -1, -1);
  endtask

  task automatic test_mid_reset();
    @(posedge clk);
    #1;
    start    = 1'b1;
    src_base = 10'h155;
    num_vec  = 10'd10;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if ({busy, done, weight_reload, result_write_enable} !== 4'b0 || sram_address !== '0 ||
        weight_address !== '0 || result_address !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b we=%b sa=%h wa=%0d ra=%0d exp all 0", busy,
               result_write_enable, sram_address, weight_address, result_address);
    end
    @(negedge clk);
    rstn     = 1'b1;
    m_sram   = '0;
    m_waddr  = '0;
    m_raddr  = '0;
    mc_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int j = 0; j < 30; j++) begin
      int n, ab, xs;
      n  = $urandom_range(0, 12);
      ab = -1;
      xs = -1;
      if (n > 0 && $urandom_range(0, 3) == 0) ab = $urandom_range(1, n + 3);
      else if (n > 0 && $urandom_range(0, 3) == 0) xs = $urandom_range(1, n + 2);
      run_job(AW'($urandom), n, WW'($urandom_range(0, 1)), ab, xs);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_abort();
    test_ignored_start();
    test_cache();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
